// File: rtl/mips_cpu_alu_pkg.sv
// Shared ALU definitions for the MIPS execute stage.
// Holds the 5-bit ALU control codes used by the decoder, the ALU and the
// HI/LO unit. Also holds the divider sequencing state enum and a helper
// that recognises the HI/LO control codes.
package mips_cpu_alu_pkg;

  localparam logic [4:0] ALU_MULTU = 5'b00111;
  localparam logic [4:0] ALU_MULT  = 5'b01000;
  localparam logic [4:0] ALU_DIV   = 5'b01111;
  localparam logic [4:0] ALU_DIVU  = 5'b10000;
  localparam logic [4:0] ALU_MTHI  = 5'b10001;
  localparam logic [4:0] ALU_MTLO  = 5'b10010;
  localparam logic [4:0] ALU_MFHI  = 5'b11010;
  localparam logic [4:0] ALU_MFLO  = 5'b11011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

  // True for every control code the HI/LO unit executes.
  function automatic logic is_hilo_op(input logic [4:0] code);
    logic hit;
    hit = 1'b0;
    case (code)
      ALU_MULTU, ALU_MULT, ALU_DIV, ALU_DIVU,
      ALU_MTHI, ALU_MTLO, ALU_MFHI, ALU_MFLO: hit = 1'b1;
      default:                                hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/mips_cpu_divider.sv
// Iterative unsigned 32/32 restoring divider, one quotient bit per cycle.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   start       - load dividend/divisor and begin 32 iterations
//   dividend    - unsigned dividend
//   divisor     - unsigned divisor
//   done        - high in the cycle that performs the final iteration;
//                 quotient/remainder are final in the following cycle
//   quotient    - quotient register
//   remainder   - remainder register
// A zero divisor naturally yields quotient = all ones, remainder = dividend.
module mips_cpu_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] rem_shift;
  logic [32:0] trial;
  logic        fits;

  always_comb begin
    // Bring the next dividend bit into the partial remainder and try to
    // subtract the divisor; keep the difference only when it does not borrow.
    rem_shift = {rem_q, quo_q[31]};
    fits      = (rem_shift >= {1'b0, dvs_q});
    trial     = rem_shift - {1'b0, dvs_q};
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    if (start) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
      cnt_d = 6'd32;
    end else if (cnt_q != 6'd0) begin
      cnt_d = cnt_q - 6'd1;
      if (fits) begin
        rem_d = trial[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = rem_shift[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign done      = (cnt_q == 6'd1);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mips_cpu_hilo_unit.sv
// MIPS multiply/divide unit holding the architectural HI and LO registers.
// Executes MULT/MULTU (single cycle), DIV/DIVU (33 busy cycles), MTHI/MTLO
// and MFHI/MFLO. Stalls any HI/LO instruction while a divide is running.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   en           - execute stage holds a valid instruction
//   alucontrol   - 5-bit ALU control code
//   a, b         - rs / rt operands
//   busy         - divide in progress
//   stall        - hold the instruction in execute this cycle
//   result       - MFHI/MFLO read data, zero for other codes
//   hi, lo       - HI and LO registers
//   div_by_zero  - sticky: the last divide had b == 0
module mips_cpu_hilo_unit
  import mips_cpu_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [4:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  div_state_e        state_q;
  logic [WIDTH-1:0]  hi_q, lo_q;
  logic [WIDTH-1:0]  a_q;          // raw dividend, returned in HI on divide by zero
  logic              neg_quo_q;
  logic              neg_rem_q;
  logic              zero_q;
  logic              dbz_q;

  logic              hilo_op;
  logic              accept;
  logic              is_div;
  logic              is_sdiv;
  logic              mul_signed;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [2*WIDTH-1:0] a_ext, b_ext, product;
  logic              div_done;
  logic [WIDTH-1:0]  div_quo, div_rem;
  logic [WIDTH-1:0]  quo_fix, rem_fix;

  assign hilo_op = is_hilo_op(alucontrol);
  assign busy    = (state_q != DIV_IDLE);
  assign stall   = en & hilo_op & busy;
  assign accept  = en & hilo_op & ~busy;

  assign is_sdiv = (alucontrol == ALU_DIV);
  assign is_div  = is_sdiv | (alucontrol == ALU_DIVU);

  // Signed divide runs on magnitudes; 0x80000000 stays 0x80000000, which is
  // the correct unsigned magnitude.
  assign a_mag = (is_sdiv & a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_sdiv & b[WIDTH-1]) ? -b : b;

  // One multiplier serves both MULT and MULTU: sign- or zero-extend to 64
  // bits and keep the low 64 bits of the product.
  assign mul_signed = (alucontrol == ALU_MULT);
  assign a_ext      = {{WIDTH{mul_signed & a[WIDTH-1]}}, a};
  assign b_ext      = {{WIDTH{mul_signed & b[WIDTH-1]}}, b};
  assign product    = a_ext * b_ext;

  mips_cpu_divider u_divider (
    .clk       (clk),
    .reset     (reset),
    .start     (accept & is_div),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Quotient is negative when operand signs differ; remainder follows the
  // dividend. Both flags are zero for DIVU.
  assign quo_fix = neg_quo_q ? -div_quo : div_quo;
  assign rem_fix = neg_rem_q ? -div_rem : div_rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= DIV_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      a_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (accept) begin
            case (alucontrol)
              ALU_MULT, ALU_MULTU: begin
                hi_q <= product[2*WIDTH-1:WIDTH];
                lo_q <= product[WIDTH-1:0];
              end
              ALU_MTHI: hi_q <= a;
              ALU_MTLO: lo_q <= a;
              ALU_DIV, ALU_DIVU: begin
                a_q       <= a;
                neg_quo_q <= is_sdiv & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_rem_q <= is_sdiv & a[WIDTH-1];
                zero_q    <= (b == '0);
                dbz_q     <= (b == '0);
                state_q   <= DIV_RUN;
              end
              default: ;
            endcase
          end
        end
        DIV_RUN: begin
          if (div_done) state_q <= DIV_FIX;
        end
        DIV_FIX: begin
          if (zero_q) begin
            lo_q <= '1;
            hi_q <= a_q;
          end else begin
            lo_q <= quo_fix;
            hi_q <= rem_fix;
          end
          state_q <= DIV_IDLE;
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  always_comb begin
    result = '0;
    if (alucontrol == ALU_MFHI)      result = hi_q;
    else if (alucontrol == ALU_MFLO) result = lo_q;
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mips_cpu_hilo_unit.sv
module tb_mips_cpu_hilo_unit;
  import mips_cpu_alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  alucontrol;
  logic [31:0] a, b;
  logic        busy, stall, div_by_zero;
  logic [31:0] result, hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference architectural state
  logic [31:0] m_hi, m_lo;
  logic        m_dbz;

  mips_cpu_hilo_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .alucontrol  (alucontrol),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .stall       (stall),
    .result      (result),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Architectural rules applied with plain integer arithmetic.
  task automatic model(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv);
    int sa, sb;
    longint sp;
    longint unsigned ua, ub, up;
    sa = av;
    sb = bv;
    case (op)
      ALU_MULT: begin
        sp = longint'(sa) * longint'(sb);
        m_hi = sp[63:32];
        m_lo = sp[31:0];
      end
      ALU_MULTU: begin
        ua = {32'b0, av};
        ub = {32'b0, bv};
        up = ua * ub;
        m_hi = up[63:32];
        m_lo = up[31:0];
      end
      ALU_DIV: begin
        if (sb == 0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = av; m_dbz = 1'b1;
        end else if (sa == 32'sh8000_0000 && sb == -1) begin
          m_lo = 32'h8000_0000; m_hi = 32'd0; m_dbz = 1'b0;
        end else begin
          m_lo = sa / sb; m_hi = sa % sb; m_dbz = 1'b0;
        end
      end
      ALU_DIVU: begin
        if (bv == 0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = av; m_dbz = 1'b1;
        end else begin
          m_lo = av / bv; m_hi = av % bv; m_dbz = 1'b0;
        end
      end
      ALU_MTHI: m_hi = av;
      ALU_MTLO: m_lo = av;
      default: ;
    endcase
  endtask

  // Called just after a falling edge. Holds the instruction until it is no
  // longer stalled, samples result, lets one rising edge pass, returns at
  // the next falling edge with en low.
  task automatic issue(input logic en_v, input logic [4:0] op, input logic [31:0] av,
                       input logic [31:0] bv, output int stalls, output logic [31:0] res);
    en = en_v; alucontrol = op; a = av; b = bv; stalls = 0;
    #1;
    while (stall && stalls < 200) begin
      @(negedge clk); #1;
      stalls++;
    end
    if (stall) check("stall_timeout", {31'b0, stall}, 32'd0);
    res = result;
    if (en_v && is_hilo_op(op)) model(op, av, bv);
    @(posedge clk); #1;
    en = 1'b0; alucontrol = 5'b00000;
    @(negedge clk);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("busy_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_hi"}, hi, m_hi);
    check({tag, "_lo"}, lo, m_lo);
    check({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, m_dbz});
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = $urandom_range(0, 20);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int st, n;
    logic [31:0] r;
    logic [4:0] ops [11];
    logic [4:0] op;
    logic [31:0] av, bv;
    logic en_v, was_busy;
    logic [31:0] exp_res;

    ops = '{ALU_MULTU, ALU_MULT, ALU_DIV, ALU_DIVU, ALU_MTHI, ALU_MTLO,
            ALU_MFHI, ALU_MFLO, 5'b00010, 5'b00000, 5'b11111};

    reset = 1'b1; en = 1'b0; alucontrol = 5'b0; a = 32'd0; b = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0; m_dbz = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_stall", {31'b0, stall}, 32'd0);
    check_state("reset");
    $display("[TB] reset checked");

    // MULT then MFHI in the next cycle: new value, no stall
    issue(1'b1, ALU_MULT, 32'hFFFF_FFFE, 32'd3, st, r);
    check("mult_busy", {31'b0, busy}, 32'd0);
    check("mult_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_lo_const", lo, 32'hFFFF_FFFA);
    issue(1'b1, ALU_MFHI, 32'd0, 32'd0, st, r);
    check("mfhi_after_mult_stall", st, 0);
    check("mfhi_after_mult", r, 32'hFFFF_FFFF);
    $display("[TB] MULT 0xfffffffe*3 hi=%08h lo=%08h", hi, lo);

    issue(1'b1, ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st, r);
    check("multu_hi_const", hi, 32'hFFFF_FFFE);
    check("multu_lo_const", lo, 32'h0000_0001);
    $display("[TB] MULTU ffffffff*ffffffff hi=%08h lo=%08h", hi, lo);

    // DIV -7/2 with MFLO stalled behind it
    issue(1'b1, ALU_DIV, 32'hFFFF_FFF9, 32'd2, st, r);
    issue(1'b1, ALU_MFLO, 32'd0, 32'd0, st, r);
    check("div_mflo_stall_cycles", st, 33);
    check("div_mflo_result", r, 32'hFFFF_FFFD);
    check("div_lo_const", lo, 32'hFFFF_FFFD);
    check("div_hi_const", hi, 32'hFFFF_FFFF);
    $display("[TB] DIV -7/2 stalls=%0d result=%08h", st, r);

    // Busy length with en low (HI/LO code present but not valid)
    issue(1'b1, ALU_DIVU, 32'd100, 32'd7, st, r);
    en = 1'b0; alucontrol = ALU_MTHI; a = 32'hDEAD_BEEF;
    #1;
    check("en0_no_stall", {31'b0, stall}, 32'd0);
    wait_idle(n);
    alucontrol = 5'b0;
    check("div_busy_cycles", n, 33);
    check_state("divu_100_7");
    $display("[TB] DIVU 100/7 busy=%0d lo=%08h hi=%08h", n, lo, hi);

    // Divide by zero, then cleared by a good divide
    issue(1'b1, ALU_DIVU, 32'd100, 32'd0, st, r);
    wait_idle(n);
    check("dbz_lo", lo, 32'hFFFF_FFFF);
    check("dbz_hi", hi, 32'd100);
    check("dbz_flag", {31'b0, div_by_zero}, 32'd1);
    issue(1'b1, ALU_DIVU, 32'd10, 32'd3, st, r);
    wait_idle(n);
    check("divu_10_3_lo", lo, 32'd3);
    check("divu_10_3_hi", hi, 32'd1);
    check("dbz_cleared", {31'b0, div_by_zero}, 32'd0);
    $display("[TB] DIVU by zero then 10/3 lo=%08h hi=%08h dbz=%0d", lo, hi, div_by_zero);

    issue(1'b1, ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, st, r);
    wait_idle(n);
    check("intmin_lo", lo, 32'h8000_0000);
    check("intmin_hi", hi, 32'd0);
    $display("[TB] DIV 80000000/-1 lo=%08h hi=%08h", lo, hi);

    // Non-HI/LO instruction passes through a running divide
    issue(1'b1, ALU_DIV, 32'd1000, 32'hFFFF_FFFD, st, r);
    issue(1'b1, 5'b00010, 32'd5, 32'd6, st, r);
    check("passthru_stall", st, 0);
    check("passthru_result", r, 32'd0);
    check("passthru_busy", {31'b0, busy}, 32'd1);
    wait_idle(n);
    check_state("div_1000_m3");
    $display("[TB] non-HI/LO op during divide stalls=%0d", st);

    // Reset during busy cycle 10
    issue(1'b1, ALU_MTLO, 32'd5, 32'd0, st, r);
    issue(1'b1, ALU_DIV, 32'd12345, 32'd17, st, r);
    repeat (9) @(negedge clk);
    check("pre_reset_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0; m_dbz = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check_state("abort");
    issue(1'b1, ALU_MTHI, 32'h1234_5678, 32'd0, st, r);
    issue(1'b1, ALU_MFHI, 32'd0, 32'd0, st, r);
    check("mthi_mfhi_stall", st, 0);
    check("mthi_mfhi_result", r, 32'h1234_5678);
    $display("[TB] reset mid-divide, MTHI/MFHI result=%08h", r);

    // Randomized traffic against the reference model
    for (int i = 0; i < 150; i++) begin
      op = ops[$urandom_range(0, 10)];
      av = rand_operand();
      bv = rand_operand();
      en_v = ($urandom_range(0, 9) != 0);
      was_busy = busy;
      exp_res = (op == ALU_MFHI) ? m_hi : ((op == ALU_MFLO) ? m_lo : 32'd0);
      issue(en_v, op, av, bv, st, r);
      if (op == ALU_MFHI || op == ALU_MFLO) begin
        // a stalled read sees the divide's result, which model already holds
        check("rnd_result", r, exp_res);
      end
      if (!was_busy || !en_v || !is_hilo_op(op)) check("rnd_no_stall", st, 0);
      if (!busy) check_state("rnd");
      else if ($urandom_range(0, 1) == 1) begin
        wait_idle(n);
        check_state("rnd_div");
      end
      $display("[TB] rnd %0d op=%05b en=%0d a=%08h b=%08h stalls=%0d hi=%08h lo=%08h",
               i, op, en_v, av, bv, st, hi, lo);
    end
    wait_idle(n);
    check_state("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_cpu_hilo_unit.md
# mips_cpu_hilo_unit

Multiply/divide execution unit holding the architectural HI and LO registers. Sits in the execute stage beside the main ALU, consumes the 5-bit ALU control code from the ALU decoder together with the rs/rt operands, and executes MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO. Multiplies complete in one cycle. Divides run as a 32-iteration restoring sequence. The unit raises a stall while any HI/LO access must wait for a divide to finish.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge; the only clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  execute stage holds a valid instruction this cycle.
- alucontrol  in  5  ALU control code from the ALU decoder.
- a  in  32  rs operand: dividend, multiplicand, or MTHI/MTLO source.
- b  in  32  rt operand: divisor or multiplier.
- busy  out  1  divide in progress.
- stall  out  1  the instruction in execute must be held this cycle.
- result  out  32  MFHI/MFLO read data.
- hi  out  32  HI register.
- lo  out  32  LO register.
- div_by_zero  out  1  sticky flag: the last divide had b == 0.

## Operation
- HI/LO codes: MULTU 00111, MULT 01000, DIV 01111, DIVU 10000, MTHI 10001, MTLO 10010, MFHI 11010, MFLO 11011. Any other code is ignored and never stalls.
- Accept condition: en & HI/LO code & !busy.
- MULT/MULTU: 64-bit product; HI = product[63:32], LO = product[31:0]. MULT is signed and MULTU is unsigned.
- MTHI/MTLO: HI or LO = a.
- MFHI/MFLO: result = hi or lo, combinational from the registers. result = 0 for any other code.
- DIV/DIVU: accepting the instruction latches the operand magnitudes and the signs, then enters state DIV.
- State machine: IDLE, DIV, FIX.
  - IDLE → DIV on an accepted divide.
  - DIV: runs 32 iterations, one quotient bit per cycle, then → FIX.
  - FIX: applies sign correction and writes HI/LO, then → IDLE.
- Signed divide rules: quotient truncates toward zero; remainder takes the sign of the dividend.
- 0x80000000 / -1: LO = 0x80000000, HI = 0.
- Divide by zero (signed or unsigned): LO = 0xFFFFFFFF, HI = a, and div_by_zero is set.
  - div_by_zero is cleared by the next accepted divide whose b is nonzero.
- stall = en & HI/LO code & busy. No instruction is accepted while stall is high, and a stalled instruction has no effect.

## Timing
- Reset: hi = 0, lo = 0, busy = 0, stall = 0, div_by_zero = 0, state IDLE.
- Reset in the middle of a divide aborts the divide. HI/LO are cleared, with no partial writeback.
- MULT/MULTU/MTHI/MTLO accepted at edge E: the new HI/LO value is visible in the cycle after E.
- An MFHI/MFLO issued in the cycle after a MULT reads the new value, with no stall.
- DIV/DIVU accepted at edge E0:
  - busy = 1 for exactly 33 cycles, starting in the cycle after E0 (32 DIV cycles + 1 FIX).
  - HI/LO are written at the FIX edge and are valid in the first cycle with busy = 0.
- An instruction held by stall is accepted at the first edge with busy = 0 and sees the divide's results.
- A non-HI/LO instruction arriving while busy passes through: stall = 0 and the divide continues.
- en = 0 never starts an operation and never stalls.

## Structure
- Shared package mips_cpu_alu_pkg: the ALU control code constants above, used by the decoder, the ALU and this unit, plus the divider state enum.
- Sub-module mips_cpu_divider: iterative unsigned 32/32 restoring divider.
  - Interface: start, dividend, divisor, done, quotient, remainder.
- Sign handling, HI/LO registers and the stall logic stay in the top module.

## Test plan
- MULT a=0xFFFFFFFE, b=3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA one cycle after issue; busy stays 0.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2, then MFLO issued the next cycle:
  - busy is high for 33 cycles and stall is high for the MFLO throughout.
  - Final values: LO=0xFFFFFFFD, HI=0xFFFFFFFF, and result=0xFFFFFFFD on release.
- DIVU a=100, b=0 → LO=0xFFFFFFFF, HI=100, div_by_zero=1.
  - A following DIVU 10/3 → LO=3, HI=1, div_by_zero=0.
- DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- Reset asserted on busy cycle 10 of a divide → next cycle busy=0, hi=lo=0.
  - Then MTHI 0x12345678 followed by MFHI → result=0x12345678 with no stall.
